axi_4_lite_mst: RTL and testbench

- Single-outstanding AXI4-Lite master that turns simple user read/write commands into AXI4-Lite transactions.
- Sits directly upstream of the team's AXI4-Lite register-file slave, which it drives over the full five-channel interface.
- Returns read data and the response code to the user on a ready/valid response port.
- Used as the bus driver in integration benches and as the CPU-less register programmer in system top levels.

---
 rtl/axi_4_lite_mst_pkg.sv | 33 +++
 rtl/axi_4_lite_mst.sv | 206 ++++++++++++++++++++
 tb/tb_axi_4_lite_mst.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_4_lite_mst_pkg.sv
// Shared widths, AXI response/protection codes and FSM state encoding for the
// single-outstanding AXI4-Lite master.
package axi_4_lite_mst_pkg;

  // Default bus widths; DATA_WIDTH must be 32 or 64
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  // AXI response codes (BRESP / RRESP)
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access on both address channels
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Master FSM states
  typedef enum logic [2:0] {
    AXI_MST_ST_IDLE = 3'd0,  // waiting for a user command
    AXI_MST_ST_WR   = 3'd1,  // AW and W channels in flight
    AXI_MST_ST_WR_B = 3'd2,  // waiting for the write response
    AXI_MST_ST_RD_A = 3'd3,  // AR channel in flight
    AXI_MST_ST_RD_R = 3'd4,  // waiting for read data
    AXI_MST_ST_RSP  = 3'd5   // presenting the result to the user
  } axi_mst_state_e;

  // SLVERR and DECERR both carry bit 1 set
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: accepts one user read/write command,
// runs it over the five AXI4-Lite channels and returns data plus the response
// code on a ready/valid response port. Every output comes from a flop.
module axi_4_lite_mst
  import axi_4_lite_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,

  // User command port
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  input  logic [STRB_WIDTH-1:0] CMD_WSTRB,

  // User response port
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]            RSP_RESP,
  output logic                  RSP_WRITE,

  // Write address channel
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,

  // Write data channel
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,

  // Write response channel
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [1:0]            M_AXI_BRESP,

  // Read address channel
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,

  // Read data channel
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP
);

  axi_mst_state_e state;

  // AW and W complete independently; each flag remembers its handshake
  logic aw_done;
  logic w_done;

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic ar_fire;
  logic r_fire;
  logic rsp_fire;
  logic aw_complete;
  logic w_complete;

  assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire   = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_fire   = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_fire  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire   = M_AXI_RVALID  && M_AXI_RREADY;
  assign rsp_fire = RSP_VALID     && RSP_READY;

  // A channel counts as complete if it finished earlier or is finishing now,
  // so same-cycle and either-order handshakes both leave WR in one step.
  assign aw_complete = aw_done || aw_fire;
  assign w_complete  = w_done  || w_fire;

  // Protection attributes never change
  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

  // Transaction sequencer: command accept, channel handshakes, response hold
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= AXI_MST_ST_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      CMD_READY     <= 1'b1;
      RSP_VALID     <= 1'b0;
      RSP_RDATA     <= {DATA_WIDTH{1'b0}};
      RSP_RESP      <= AXI_RESP_OKAY;
      RSP_WRITE     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_AWADDR  <= {ADDR_WIDTH{1'b0}};
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WDATA   <= {DATA_WIDTH{1'b0}};
      M_AXI_WSTRB   <= {STRB_WIDTH{1'b0}};
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= {ADDR_WIDTH{1'b0}};
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        AXI_MST_ST_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            if (CMD_WRITE) begin
              // Address, data and strobe stay frozen until their VALIDs drop
              M_AXI_AWADDR  <= CMD_ADDR;
              M_AXI_WDATA   <= CMD_WDATA;
              M_AXI_WSTRB   <= CMD_WSTRB;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= AXI_MST_ST_WR;
            end else begin
              M_AXI_ARADDR  <= CMD_ADDR;
              M_AXI_ARVALID <= 1'b1;
              state         <= AXI_MST_ST_RD_A;
            end
          end
        end

        AXI_MST_ST_WR: begin
          if (aw_fire) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_complete && w_complete) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state        <= AXI_MST_ST_WR_B;
          end
        end

        AXI_MST_ST_WR_B: begin
          if (b_fire) begin
            M_AXI_BREADY <= 1'b0;
            RSP_RESP     <= M_AXI_BRESP;
            RSP_RDATA    <= {DATA_WIDTH{1'b0}};
            RSP_WRITE    <= 1'b1;
            RSP_VALID    <= 1'b1;
            state        <= AXI_MST_ST_RSP;
          end
        end

        AXI_MST_ST_RD_A: begin
          if (ar_fire) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= AXI_MST_ST_RD_R;
          end
        end

        AXI_MST_ST_RD_R: begin
          if (r_fire) begin
            M_AXI_RREADY <= 1'b0;
            RSP_RDATA    <= M_AXI_RDATA;
            RSP_RESP     <= M_AXI_RRESP;
            RSP_WRITE    <= 1'b0;
            RSP_VALID    <= 1'b1;
            state        <= AXI_MST_ST_RSP;
          end
        end

        AXI_MST_ST_RSP: begin
          // Response payload is held; only VALID changes on the handshake
          if (rsp_fire) begin
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= AXI_MST_ST_IDLE;
          end
        end

        default: begin
          // Unused encoding: drop every handshake signal and go idle
          state         <= AXI_MST_ST_IDLE;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
          CMD_READY     <= 1'b1;
          RSP_VALID     <= 1'b0;
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: a behavioural register-file slave with
// programmable channel latencies, and a queue of expected user responses.
module tb_axi_4_lite_mst;
  import axi_4_lite_mst_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;

  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write;

  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;

  logic        awready = 1'b0;
  logic        wready  = 1'b0;
  logic        bvalid  = 1'b0;
  logic [1:0]  bresp   = 2'b00;
  logic        arready = 1'b0;
  logic        rvalid  = 1'b0;
  logic [31:0] rdata   = 32'h0;
  logic [1:0]  rresp   = 2'b00;

  axi_4_lite_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
    .RSP_RESP(rsp_resp), .RSP_WRITE(rsp_write),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration: ready/valid latencies in cycles and forced responses
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Slave bookkeeping
  logic [31:0] mem [0:15];
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int          aw_cyc = 0, w_cyc = 0;

  // Register-file slave; acts on the falling edge, so a handshake that
  // happened on a rising edge is seen via the values recorded one half
  // cycle before it.
  initial begin
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_l, w_data_l, r_addr_l;
    logic [3:0]  w_strb_l;
    logic        rec_awv, rec_wv, rec_arv, rec_bready, rec_rready;
    logic [31:0] rec_awaddr, rec_wdata, rec_araddr;
    logic [3:0]  rec_wstrb;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    aw_addr_l = 32'h0; w_data_l = 32'h0; r_addr_l = 32'h0; w_strb_l = 4'h0;
    rec_awv = 1'b0; rec_wv = 1'b0; rec_arv = 1'b0; rec_bready = 1'b0; rec_rready = 1'b0;
    rec_awaddr = 32'h0; rec_wdata = 32'h0; rec_araddr = 32'h0; rec_wstrb = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        rec_awv = 1'b0; rec_wv = 1'b0; rec_arv = 1'b0; rec_bready = 1'b0; rec_rready = 1'b0;
      end else begin
        if (rec_awv && awready) begin
          aw_got = 1'b1; aw_addr_l = rec_awaddr; aw_hs++; aw_cyc = cyc; awready = 1'b0; aw_cnt = 0;
        end
        if (rec_wv && wready) begin
          w_got = 1'b1; w_data_l = rec_wdata; w_strb_l = rec_wstrb; w_hs++; w_cyc = cyc; wready = 1'b0; w_cnt = 0;
        end
        if (rec_arv && arready) begin
          r_pend = 1'b1; r_cnt = 0; r_addr_l = rec_araddr; ar_hs++; arready = 1'b0; ar_cnt = 0;
        end
        if (bvalid && rec_bready) begin
          bvalid = 1'b0; bresp = 2'b00; b_hs++;
        end
        if (rvalid && rec_rready) begin
          rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; r_hs++;
        end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (w_strb_l[b]) mem[aw_addr_l[5:2]][8*b +: 8] = w_data_l[8*b +: 8];
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
        end
        if (awvalid && !awready) begin
          aw_cnt++; if (aw_cnt > aw_dly) awready = 1'b1;
        end
        if (wvalid && !wready) begin
          w_cnt++; if (w_cnt > w_dly) wready = 1'b1;
        end
        if (arvalid && !arready) begin
          ar_cnt++; if (ar_cnt > ar_dly) arready = 1'b1;
        end
        if (b_pend && !bvalid) begin
          b_cnt++;
          if (b_cnt > b_dly) begin bvalid = 1'b1; bresp = bresp_cfg; b_pend = 1'b0; end
        end
        if (r_pend && !rvalid) begin
          r_cnt++;
          if (r_cnt > r_dly) begin
            rvalid = 1'b1; rdata = mem[r_addr_l[5:2]]; rresp = rresp_cfg; r_pend = 1'b0;
          end
        end
        rec_awv = awvalid; rec_awaddr = awaddr;
        rec_wv = wvalid; rec_wdata = wdata; rec_wstrb = wstrb;
        rec_arv = arvalid; rec_araddr = araddr;
        rec_bready = bready; rec_rready = rready;
      end
    end
  end

  // Present one command (called just after a falling edge); queue its expected result
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] eresp, input logic [31:0] erdata);
    exp_t e;
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_wait: CMD_READY=%b, expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    e.wr = wr; e.resp = eresp; e.rdata = erdata;
    exp_q.push_back(e);
  endtask

  // Wait for the response, hold RSP_READY low for 'hold' cycles, then pop and compare
  task automatic collect(input int hold, input string tag);
    exp_t e;
    logic [31:0] d0;
    logic [1:0]  r0;
    int guard = 0;
    rsp_ready = 1'b0;
    while (rsp_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_rsp_timeout: RSP_VALID=%b, expected 1", tag, rsp_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    d0 = rsp_rdata; r0 = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || rsp_resp !== r0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_rsp_hold: valid=%b rdata=%h resp=%b cmd_ready=%b, expected 1/%h/%b/0",
                 tag, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, d0, r0);
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_scoreboard: response with no expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (rsp_write !== e.wr || rsp_resp !== e.resp || rsp_rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL %s_rsp: write=%b resp=%b rdata=%h, expected %b/%b/%h",
                 tag, rsp_write, rsp_resp, rsp_rdata, e.wr, e.resp, e.rdata);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rsp_release: RSP_VALID=%b CMD_READY=%b, expected 0/1", tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || {awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_handshake: cmd_ready=%b aw/w/b/ar/r=%b, expected 1/00000",
               cmd_ready, {awvalid, wvalid, bready, arvalid, rready});
    end
    n_checks++;
    if ({rsp_valid, rsp_write, rsp_resp} !== 4'b0000 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b write=%b resp=%b rdata=%h, expected all 0",
               rsp_valid, rsp_write, rsp_resp, rsp_rdata);
    end
    n_checks++;
    if (awaddr !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 ||
        awprot !== 3'b000 || arprot !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h wstrb=%h prot=%b/%b, expected 0",
               awaddr, araddr, wdata, wstrb, awprot, arprot);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int aw0 = aw_hs, w0 = w_hs;
    aw_dly = 0; w_dly = 1;
    issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, AXI_RESP_OKAY, 32'h0);
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_valids_together: awvalid=%b wvalid=%b cmd_ready=%b, expected 1/1/0",
               awvalid, wvalid, cmd_ready);
    end
    collect(0, "wr_deadbeef");
    n_checks++;
    if (w_cyc != aw_cyc + 1 || aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
      n_fail++;
      $display("FAIL wr_order: aw_cyc=%0d w_cyc=%0d aw_hs=%0d w_hs=%0d, expected w one after aw, 1 each",
               aw_cyc, w_cyc, aw_hs - aw0, w_hs - w0);
    end
    w_dly = 0;
    issue(1'b0, 32'h4, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hDEADBEEF);
    n_checks++;
    if (arvalid !== 1'b1 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_arvalid: arvalid=%b awvalid=%b, expected 1/0", arvalid, awvalid);
    end
    collect(0, "rd_deadbeef");
  endtask

  task automatic test_partial_strobe();
    issue(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, AXI_RESP_OKAY, 32'h0);
    collect(0, "wr_base");
    issue(1'b1, 32'h8, 32'h11223344, 4'h3, AXI_RESP_OKAY, 32'h0);
    collect(0, "wr_strb3");
    issue(1'b0, 32'h8, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hAABB3344);
    collect(0, "rd_merged");
  endtask

  task automatic test_reverse_order();
    int aw0 = aw_hs, w0 = w_hs, b0 = b_hs;
    aw_dly = 3; w_dly = 0;
    issue(1'b1, 32'hC, 32'h55AA55AA, 4'hF, AXI_RESP_OKAY, 32'h0);
    collect(0, "wr_w_first");
    n_checks++;
    if (!(w_cyc < aw_cyc) || aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      n_fail++;
      $display("FAIL w_first_order: aw_cyc=%0d w_cyc=%0d aw/w/b hs=%0d/%0d/%0d, expected w<aw, 1/1/1",
               aw_cyc, w_cyc, aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    aw_dly = 1; w_dly = 1;
    issue(1'b1, 32'hC, 32'h0F0F0F0F, 4'hF, AXI_RESP_OKAY, 32'h0);
    collect(0, "wr_same_cycle");
    n_checks++;
    if (w_cyc != aw_cyc || aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      n_fail++;
      $display("FAIL same_cycle_order: aw_cyc=%0d w_cyc=%0d aw/w/b hs=%0d/%0d/%0d, expected equal, 1/1/1",
               aw_cyc, w_cyc, aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    aw_dly = 0; w_dly = 0;
    issue(1'b0, 32'hC, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h0F0F0F0F);
    collect(0, "rd_same_cycle");
  endtask

  task automatic test_delayed_read();
    r_dly = 5;
    issue(1'b0, 32'h4, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hDEADBEEF);
    collect(3, "rd_delayed");
    r_dly = 0;
  endtask

  task automatic test_error_resp();
    bresp_cfg = AXI_RESP_SLVERR;
    issue(1'b1, 32'h14, 32'h00000001, 4'hF, AXI_RESP_SLVERR, 32'h0);
    collect(0, "wr_slverr");
    bresp_cfg = AXI_RESP_OKAY;
    rresp_cfg = AXI_RESP_DECERR;
    issue(1'b0, 32'h14, 32'h0, 4'h0, AXI_RESP_DECERR, 32'h00000001);
    collect(0, "rd_decerr");
    rresp_cfg = AXI_RESP_OKAY;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    b_dly = 20;
    issue(1'b1, 32'h18, 32'h00000099, 4'hF, AXI_RESP_OKAY, 32'h0);
    while (bready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    n_checks++;
    if (bready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reach_wr_b: BREADY=%b, expected 1", bready);
    end
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b000000 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: aw/w/b/ar/r/rsp=%b cmd_ready=%b, expected 000000/1",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, cmd_ready);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    #1 rst_n = 1'b1;
    b_dly = 0;
    @(negedge clk);
    issue(1'b1, 32'h18, 32'h00000077, 4'hF, AXI_RESP_OKAY, 32'h0);
    collect(0, "wr_after_reset");
    issue(1'b0, 32'h18, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h00000077);
    collect(0, "rd_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [0:3];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      aw_dly = $urandom_range(0, 2);
      w_dly  = $urandom_range(0, 2);
      issue(1'b1, 32'h20 + 32'(4 * i), vals[i], 4'hF, AXI_RESP_OKAY, 32'h0);
      collect(0, "b2b_wr");
    end
    for (int i = 0; i < 4; i++) begin
      ar_dly = $urandom_range(0, 2);
      r_dly  = $urandom_range(0, 2);
      issue(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0, AXI_RESP_OKAY, vals[i]);
      collect(i % 2, "b2b_rd");
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_reverse_order();
    test_delayed_read();
    test_error_resp();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
